clk_div_multi: RTL

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_ch.sv | 98 +++++++++
 rtl/clk_div_multi.sv | 60 ++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, channel state type and index-width helper for the multi-channel clock divider.
package clk_div_pkg;

   localparam int DEF_DIV_W    = 8;
   localparam int DEF_RST_HALF = 3;

   typedef enum logic {
      CH_STOP = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   // Channel-select width; never narrower than one bit so a single channel still has a port.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active H, one-deep pending config and glitch-free stop.
// Optional tick strobe output when CLKDIV_TICK_EN is defined.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int DIV_W    = DEF_DIV_W,
   parameter int RST_HALF = DEF_RST_HALF
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_we,
   input  logic [DIV_W-1:0] cfg_half,
   output logic             clk_out,
   output logic             pending
`ifdef CLKDIV_TICK_EN
   ,
   output logic             tick
`endif
);

   ch_state_e        state, state_nxt;
   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic [DIV_W-1:0] half, half_nxt;
   logic [DIV_W-1:0] pend_val, pend_val_nxt;
   logic             clk_nxt, pend_nxt;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) state <= CH_STOP;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      clk_nxt      = clk_out;
      half_nxt     = half;
      pend_nxt     = pending;
      pend_val_nxt = pend_val;
      case (state)
         CH_STOP: begin
            cnt_nxt = '0;
            clk_nxt = 1'b0;
            if (pending) begin
               half_nxt = pend_val;
               pend_nxt = 1'b0;
            end
            if (en) state_nxt = CH_RUN;
         end
         CH_RUN: begin
            // A high phase always runs to completion; only a low output may stop at once.
            if (!en && !clk_out) begin
               state_nxt = CH_STOP;
               cnt_nxt   = '0;
            end else if (cnt == half) begin
               clk_nxt = ~clk_out;
               cnt_nxt = '0;
               if (pending) begin
                  half_nxt = pend_val;
                  pend_nxt = 1'b0;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = CH_STOP;
      endcase
      // cfg_we is only possible while pending is clear, so it never races the clear above.
      if (cfg_we) begin
         pend_nxt     = 1'b1;
         pend_val_nxt = cfg_half;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         clk_out  <= 1'b0;
         half     <= DIV_W'(RST_HALF);
         pending  <= 1'b0;
         pend_val <= '0;
      end else begin
         cnt      <= cnt_nxt;
         clk_out  <= clk_nxt;
         half     <= half_nxt;
         pending  <= pend_nxt;
         pend_val <= pend_val_nxt;
      end
   end

`ifdef CLKDIV_TICK_EN
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) tick <= 1'b0;
      else       tick <= (clk_nxt != clk_out);
   end
`endif

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent 50%-duty clock dividers sharing one configuration port.
// Define CLKDIV_TICK_EN to add the per-channel tick strobe port.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DIV_W    = DEF_DIV_W,
   parameter int RST_HALF = DEF_RST_HALF
) (
   input  logic                        clk_in,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           en,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
   input  logic [DIV_W-1:0]            cfg_half,
   output logic [NUM_CH-1:0]           clk_out
`ifdef CLKDIV_TICK_EN
   ,
   output logic [NUM_CH-1:0]           tick
`endif
);

   localparam int CH_W = ch_idx_w(NUM_CH);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] cfg_we;

   // Handshake: a request transfers on a rising clk_in edge where cfg_valid && cfg_ready;
   // cfg_ready is combinational from cfg_ch and is high for any channel with no pending value,
   // including out-of-range channels, whose requests are swallowed without effect.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign cfg_we[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

      clk_div_ch #(
         .DIV_W    (DIV_W),
         .RST_HALF (RST_HALF)
      ) u_ch (
         .clk_in   (clk_in),
         .reset    (reset),
         .en       (en[g]),
         .cfg_we   (cfg_we[g]),
         .cfg_half (cfg_half),
         .clk_out  (clk_out[g]),
         .pending  (pending[g])
`ifdef CLKDIV_TICK_EN
         ,
         .tick     (tick[g])
`endif
      );
   end

endmodule
